sram_controller: RTL and testbench

Responder side of the MEM-stage data-memory interface: it accepts the pipeline's 32-bit word read and write requests and executes them on an external 16-bit asynchronous SRAM as two half-word accesses. It sits between the EXE/MEM pipeline register and the SRAM pins, and replaces the single-cycle data memory. While an access is in flight it drops `ready`; the top level drives every stage register's `freeze` from `~ready`.

---
 rtl/mem_pkg.sv | 15 +
 rtl/sram_phase_counter.sv | 35 +++
 rtl/sram_controller.sv | 125 ++++++++++++
 tb/tb_sram_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default constants for the data-memory path
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam int SRAM_BASE_ADDR     = 1024;
  localparam int SRAM_ADDR_W        = 18;
  localparam int SRAM_ACCESS_CYCLES = 2;

endpackage

// File: rtl/sram_phase_counter.sv
// rtl/sram_phase_counter.sv - cycle counter marking the last cycle of an SRAM half-word phase
module sram_phase_counter #(
  parameter int ACCESS_CYCLES = mem_pkg::SRAM_ACCESS_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last,
  output logic last_next
);

  localparam logic [3:0] LAST_COUNT = 4'(ACCESS_CYCLES - 1);

  logic [3:0] count;
  logic [3:0] count_d;

  // Restart from zero whenever a new phase is about to begin
  always_comb begin
    count_d = clear ? 4'd0 : count + 4'd1;
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else begin
      count <= count_d;
    end
  end

  assign last      = (count == LAST_COUNT);
  // Tells the strobe logic one cycle early that the hold cycle is next
  assign last_next = (count_d == LAST_COUNT);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage loads/stores executed as two 16-bit SRAM accesses
module sram_controller #(
  parameter int BASE_ADDR     = mem_pkg::SRAM_BASE_ADDR,
  parameter int SRAM_ADDR_W   = mem_pkg::SRAM_ADDR_W,
  parameter int ACCESS_CYCLES = mem_pkg::SRAM_ACCESS_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wr_data,
  output logic [31:0]            rd_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  import mem_pkg::*;

  localparam int WORD_W = SRAM_ADDR_W - 1;

  sram_state_t       state;
  sram_state_t       state_d;
  logic              req;
  logic              last;
  logic              last_next;
  logic              phase_clear;
  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] word_q;
  logic [31:0]       data_q;
  logic              wr_q;

  assign req    = rd_en | wr_en;
  // Out-of-range addresses simply wrap inside the SRAM
  assign word_d = WORD_W'((address - 32'(BASE_ADDR)) >> 2);
  assign ready  = ~req | (state == DONE);

  // Counter restarts on every phase change and is held at zero while idle
  assign phase_clear = (state_d != state) | (state == IDLE);

  sram_phase_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (phase_clear),
    .last     (last),
    .last_next(last_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: each half-word phase ends on the counter's last cycle
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req)  state_d = LOW;
      LOW:     if (last) state_d = HIGH;
      HIGH:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, registered SRAM pins and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q      <= '0;
      data_q      <= 32'd0;
      wr_q        <= 1'b0;
      rd_data     <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            word_q      <= word_d;
            data_q      <= wr_data;
            wr_q        <= wr_en;
            sram_addr   <= {word_d, 1'b0};
            sram_dq_out <= wr_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
          end
        end
        LOW: begin
          if (last) begin
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= data_q[31:16];
            sram_we_n   <= ~wr_q;
            if (!wr_q) rd_data[15:0] <= sram_dq_in;
          end else begin
            sram_we_n <= ~wr_q | last_next;
          end
        end
        HIGH: begin
          if (last) begin
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!wr_q) rd_data[31:16] <= sram_dq_in;
          end else begin
            sram_we_n <= ~wr_q | last_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller
module tb_sram_controller;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_pulses = 0;
  logic [31:0] exp_q[$];
  logic [34:0] strobes[$];
  logic [15:0] mem [0:262143];

  always #5 clk = ~clk;

  sram_controller #(
    .BASE_ADDR(1024),
    .SRAM_ADDR_W(18),
    .ACCESS_CYCLES(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n)
  );

  // SRAM model: write while strobe is low, read combinationally
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = sram_dq_oe ? 16'h0000 : mem[sram_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: logs strobes and scores each completed access
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst) begin
      cyc = 0;
    end else begin
      if (!sram_we_n) strobes.push_back({sram_addr, sram_dq_out, sram_dq_oe});
      if (rd_en || wr_en) begin
        if (ready) begin
          ready_pulses++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", {63'd0, ready}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("rd_data", {32'd0, rd_data}, {32'd0, e});
            check("latency", cyc, 2 * N + 1);
          end
          cyc = 0;
        end else begin
          cyc++;
        end
      end
    end
  end

  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] e);
    bit seen;
    seen = 1'b0;
    exp_q.push_back(e);
    rd_en = r;
    wr_en = w;
    address = a;
    wr_data = d;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    if (!seen) begin
      check("timeout", {63'd0, ready}, 64'd1);
      void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int p0;
    rst = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = 32'd0;
    wr_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", sram_addr, 0);
    check("rst_dq_out", sram_dq_out, 0);
    check("rst_oe", sram_dq_oe, 0);
    check("rst_we_n", sram_we_n, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_ready", ready, 1);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_pins", {ready, sram_we_n, sram_dq_oe}, 3'b110);
    end
    @(posedge clk);
    #1;

    strobes.delete();
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0);
    check("wr_strobe_count", strobes.size(), 2);
    if (strobes.size() == 2) begin
      check("wr_strobe_low", strobes[0], {18'd0, 16'hBEEF, 1'b1});
      check("wr_strobe_high", strobes[1], {18'd1, 16'hDEAD, 1'b1});
    end
    idle(1);

    mem[2] = 16'h1234;
    mem[3] = 16'hABCD;
    strobes.delete();
    access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hABCD1234);
    check("rd_no_strobe", strobes.size(), 0);
    idle(1);

    p0 = ready_pulses;
    access(1'b0, 1'b1, 32'd1064, 32'hCAFEF00D, 32'hABCD1234);
    access(1'b1, 1'b0, 32'd1064, 32'h0, 32'hCAFEF00D);
    idle(1);
    check("b2b_ready_pulses", ready_pulses - p0, 2);

    access(1'b1, 1'b1, 32'd1032, 32'h55AA33CC, 32'hCAFEF00D);
    idle(1);
    check("both_mem_low", mem[4], 16'h33CC);
    check("both_mem_high", mem[5], 16'h55AA);
    check("both_rd_data", rd_data, 32'hCAFEF00D);

    access(1'b1, 1'b0, 32'd525320, 32'h0, 32'h55AA33CC);
    idle(1);

    rd_en = 1'b0;
    wr_en = 1'b1;
    address = 32'd1036;
    wr_data = 32'h11112222;
    @(posedge clk);
    #1;
    check("mid_addr", sram_addr, 6);
    check("mid_we_n", sram_we_n, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_addr", sram_addr, 0);
    check("abort_dq_out", sram_dq_out, 0);
    check("abort_oe", sram_dq_oe, 0);
    check("abort_we_n", sram_we_n, 1);
    check("abort_rd_data", rd_data, 0);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 32'hABCD1234);
    idle(2);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
